// File: rtl/lightbike_pkg.sv
// Shared definitions for the light-bike input path.
//   - Direction encoding (0=up, 1=right, 2=down, 3=left)
//   - PS/2 prefix byte values
//   - Prefix parser state encoding
//   - legal_turn(): true when a new heading is neither a repeat nor a reversal
package lightbike_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    typedef enum logic [1:0] {
        PS_IDLE    = 2'd0,
        PS_EXT     = 2'd1,
        PS_BRK     = 2'd2,
        PS_EXT_BRK = 2'd3
    } ps_state_t;

    // Opposite headings differ only in bit 1 of the encoding.
    function automatic logic legal_turn(input logic [1:0] h, input logic [1:0] r);
        return (h != r) && (h != (r ^ 2'd2));
    endfunction

endpackage

// File: rtl/ps2_prefix_parser.sv
// PS/2 scan-code prefix parser.
// Tracks E0 (extended) and F0 (break) prefixes and flags make codes.
// The E0 prefix is not reported: only the 8-bit code value is passed on.
// Ports:
//   i_clock, i_resetn   clock, synchronous active-low reset
//   i_clear             synchronous return to IDLE (round start)
//   i_scan_valid        strobe: i_scan_code holds a new byte
//   i_scan_code         PS/2 byte
//   o_make_valid        combinational strobe, same cycle as the byte
//   o_make_code         the make code value
module ps2_prefix_parser
    import lightbike_pkg::*;
(
    input  logic       i_clock,
    input  logic       i_resetn,
    input  logic       i_clear,
    input  logic       i_scan_valid,
    input  logic [7:0] i_scan_code,
    output logic       o_make_valid,
    output logic [7:0] o_make_code
);

    ps_state_t r_state;
    ps_state_t w_next;

    always_ff @(posedge i_clock) begin
        if (!i_resetn || i_clear) r_state <= PS_IDLE;
        else                      r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        o_make_valid = 1'b0;
        o_make_code  = i_scan_code;
        if (i_scan_valid) begin
            unique case (r_state)
                PS_IDLE: begin
                    if (i_scan_code == PS2_EXT)        w_next = PS_EXT;
                    else if (i_scan_code == PS2_BRK)   w_next = PS_BRK;
                    else if (i_scan_code != PS2_PAUSE) o_make_valid = 1'b1;
                end
                PS_EXT: begin
                    if (i_scan_code == PS2_BRK)      w_next = PS_EXT_BRK;
                    else if (i_scan_code == PS2_EXT) w_next = PS_EXT;
                    else begin
                        o_make_valid = 1'b1;
                        w_next       = PS_IDLE;
                    end
                end
                // Byte after a break prefix is the released key: discard.
                PS_BRK, PS_EXT_BRK: w_next = PS_IDLE;
                default:            w_next = PS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_direction_latch.sv
// Player heading latch driven by PS/2 key presses.
// Presses are matched against the player's mapped keys, reversals and
// repeats are rejected, and accepted turns are queued until the game tick.
// Build option: define TURN_QUEUE_EN for a QDEPTH-deep turn queue;
// otherwise a single holding register is used.
// Ports:
//   i_clock, i_resetn         clock, synchronous active-low reset
//   i_scan_valid, i_scan_code PS/2 byte stream
//   i_key_left/right/up/down  mapped make codes
//   i_enable                  game running; presses accepted
//   i_tick                    game-step strobe, commits one queued turn
//   i_round_start             synchronous reload to INIT_DIR
//   o_dir                     committed heading
//   o_turn                    one-cycle pulse after a tick changed o_dir
//   o_pending                 a queued turn awaits the next tick
module ps2_direction_latch
    import lightbike_pkg::*;
#(
    parameter logic [1:0] INIT_DIR = 2'd1,
    parameter int         QDEPTH   = 2
) (
    input  logic       i_clock,
    input  logic       i_resetn,
    input  logic       i_scan_valid,
    input  logic [7:0] i_scan_code,
    input  logic [7:0] i_key_left,
    input  logic [7:0] i_key_right,
    input  logic [7:0] i_key_up,
    input  logic [7:0] i_key_down,
    input  logic       i_enable,
    input  logic       i_tick,
    input  logic       i_round_start,
    output logic [1:0] o_dir,
    output logic       o_turn,
    output logic       o_pending
);

`ifdef TURN_QUEUE_EN
    localparam int QD = QDEPTH;
`else
    localparam int QD = 1;
`endif
    localparam int CW = $clog2(QD + 1);

    logic              w_make_valid;
    logic [7:0]        w_make_code;

    logic [1:0]        r_dir;
    logic              r_turn;
    logic [QD-1:0][1:0] r_q;     // entry 0 is the oldest
    logic [CW-1:0]     r_cnt;

    logic [1:0]        w_dir;
    logic              w_turn;
    logic [QD-1:0][1:0] w_q;
    int                w_n;
    logic              w_hit;
    logic [1:0]        w_h;
    logic [1:0]        w_ref;
    logic [1:0]        w_below;

    ps2_prefix_parser u_parser (
        .i_clock      (i_clock),
        .i_resetn     (i_resetn),
        .i_clear      (i_round_start),
        .i_scan_valid (i_scan_valid),
        .i_scan_code  (i_scan_code),
        .o_make_valid (w_make_valid),
        .o_make_code  (w_make_code)
    );

    // Key match, priority up > right > down > left.
    always_comb begin
        w_hit = w_make_valid;
        w_h   = DIR_UP;
        if (w_make_code == i_key_up)         w_h = DIR_UP;
        else if (w_make_code == i_key_right) w_h = DIR_RIGHT;
        else if (w_make_code == i_key_down)  w_h = DIR_DOWN;
        else if (w_make_code == i_key_left)  w_h = DIR_LEFT;
        else                                 w_hit = 1'b0;
    end

    // Pop on tick first, then evaluate the press against the post-pop state.
    always_comb begin
        w_dir   = r_dir;
        w_turn  = 1'b0;
        w_q     = r_q;
        w_n     = int'(r_cnt);
        w_ref   = r_dir;
        w_below = r_dir;
        if (!i_enable) begin
            // Nothing is pushed while disabled, so this clears on the falling edge.
            w_n = 0;
        end else begin
            if (i_tick && w_n > 0) begin
                w_dir  = w_q[0];
                w_turn = 1'b1;
                for (int i = 0; i < QD - 1; i++) w_q[i] = w_q[i+1];
                w_n = w_n - 1;
            end
            w_ref   = w_dir;
            w_below = w_dir;
            for (int i = 0; i < QD; i++) begin
                if (i == w_n - 1) w_ref = w_q[i];
                if (i == w_n - 2) w_below = w_q[i];
            end
            if (w_hit) begin
                if (w_n < QD) begin
                    if (legal_turn(w_h, w_ref)) begin
                        for (int i = 0; i < QD; i++)
                            if (i == w_n) w_q[i] = w_h;
                        w_n = w_n + 1;
                    end
                end else if (legal_turn(w_h, w_below)) begin
                    // Full: replace the newest entry.
                    w_q[QD-1] = w_h;
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_resetn || i_round_start) begin
            r_dir  <= INIT_DIR;
            r_turn <= 1'b0;
            r_q    <= '0;
            r_cnt  <= '0;
        end else begin
            r_dir  <= w_dir;
            r_turn <= w_turn;
            r_q    <= w_q;
            r_cnt  <= CW'(w_n);
        end
    end

    assign o_dir     = r_dir;
    assign o_turn    = r_turn;
    assign o_pending = (r_cnt != '0);

endmodule

// File: tb/tb_ps2_direction_latch.sv
module tb_ps2_direction_latch;

`ifdef TURN_QUEUE_EN
    localparam int QD = 2;
`else
    localparam int QD = 1;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       scan_valid = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic [7:0] key_left = 8'h1C, key_right = 8'h23, key_up = 8'h1D, key_down = 8'h1B;
    logic       enable = 1'b1, tick = 1'b0, round_start = 1'b0;
    logic [1:0] dir;
    logic       turn, pending;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int       m_dir = 1;
    int       m_turn = 0;
    int       m_q[$];
    bit       m_ext = 0, m_brk = 0;

    ps2_direction_latch #(.INIT_DIR(2'd1), .QDEPTH(2)) dut (
        .i_clock(clk), .i_resetn(resetn), .i_scan_valid(scan_valid), .i_scan_code(scan_code),
        .i_key_left(key_left), .i_key_right(key_right), .i_key_up(key_up), .i_key_down(key_down),
        .i_enable(enable), .i_tick(tick), .i_round_start(round_start),
        .o_dir(dir), .o_turn(turn), .o_pending(pending)
    );

    always #5 clk = ~clk;

    function automatic bit ok_turn(int h, int r);
        return (h != r) && (h != (r ^ 2));
    endfunction

    // Behavioural model of one clock edge with the given inputs.
    task automatic model_edge(bit sv, bit [7:0] code, bit tk, bit rs, bit en, bit rn);
        int h;
        int r;
        if (!rn || rs) begin
            m_dir = 1; m_turn = 0; m_q.delete(); m_ext = 0; m_brk = 0;
            return;
        end
        m_turn = 0;
        if (!en) m_q.delete();
        else if (tk && m_q.size() > 0) begin
            m_dir = m_q.pop_front();
            m_turn = 1;
        end
        if (!sv) return;
        if (m_brk) begin m_brk = 0; m_ext = 0; return; end
        if (code == 8'hE0) begin m_ext = 1; return; end
        if (code == 8'hF0) begin m_brk = 1; return; end
        if (code == 8'hE1 && !m_ext) return;
        m_ext = 0;
        if (code == key_up) h = 0;
        else if (code == key_right) h = 1;
        else if (code == key_down) h = 2;
        else if (code == key_left) h = 3;
        else return;
        if (!en) return;
        if (m_q.size() < QD) begin
            r = (m_q.size() > 0) ? m_q[$] : m_dir;
            if (ok_turn(h, r)) m_q.push_back(h);
        end else begin
            r = (m_q.size() >= 2) ? m_q[m_q.size()-2] : m_dir;
            if (ok_turn(h, r)) m_q[m_q.size()-1] = h;
        end
    endtask

    task automatic cyc(bit sv, bit [7:0] code, bit tk, bit rs, bit en, bit rn);
        scan_valid = sv; scan_code = code; tick = tk; round_start = rs; enable = en; resetn = rn;
        @(posedge clk);
        model_edge(sv, code, tk, rs, en, rn);
        #1;
    endtask

    task automatic put(bit [7:0] code); cyc(1, code, 0, 0, 1, 1); endtask
    task automatic do_tick();           cyc(0, 8'h00, 1, 0, 1, 1); endtask
    task automatic idle();              cyc(0, 8'h00, 0, 0, 1, 1); endtask
    task automatic restart();           cyc(0, 8'h00, 0, 1, 1, 1); endtask

    task automatic test_reset();
        cyc(0, 8'h00, 0, 0, 1, 0);
        n_vec++;
        if ({dir, turn, pending} !== {2'd1, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL reset: got dir=%0d turn=%0b pend=%0b, want 1/0/0", dir, turn, pending);
        end
        idle();
    endtask

    task automatic test_basic_turn();
        restart();
        put(8'h1D);
        n_vec++;
        if (dir !== 2'd1 || pending !== 1'b1 || pending !== (m_q.size() != 0)) begin
            n_err++; $display("FAIL basic_press: got dir=%0d pend=%0b, want 1/1", dir, pending);
        end
        do_tick();
        n_vec++;
        if (dir !== 2'd0 || turn !== 1'b1 || pending !== 1'b0 || dir !== 2'(m_dir)) begin
            n_err++; $display("FAIL basic_tick: got dir=%0d turn=%0b pend=%0b, want 0/1/0", dir, turn, pending);
        end
        idle();
        n_vec++;
        if (turn !== 1'b0 || dir !== 2'd0) begin
            n_err++; $display("FAIL basic_turn_pulse: got dir=%0d turn=%0b, want 0/0", dir, turn);
        end
    endtask

    task automatic test_reversal();
        restart();
        put(8'h1C);
        n_vec++;
        if (pending !== 1'b0) begin
            n_err++; $display("FAIL reversal_pend: got %0b want 0", pending);
        end
        do_tick();
        n_vec++;
        if (dir !== 2'd1 || turn !== 1'b0) begin
            n_err++; $display("FAIL reversal_tick: got dir=%0d turn=%0b, want 1/0", dir, turn);
        end
    endtask

    task automatic test_break();
        restart();
        put(8'hF0); put(8'h1D); do_tick();
        n_vec++;
        if (dir !== 2'd1 || turn !== 1'b0 || pending !== 1'b0) begin
            n_err++; $display("FAIL break: got dir=%0d turn=%0b pend=%0b, want 1/0/0", dir, turn, pending);
        end
    endtask

    task automatic test_arrow();
        key_left = 8'h6B; key_up = 8'h75;
        restart();
        put(8'hE0); put(8'h75); do_tick();
        n_vec++;
        if (dir !== 2'd0 || turn !== 1'b1) begin
            n_err++; $display("FAIL arrow_make: got dir=%0d turn=%0b, want 0/1", dir, turn);
        end
        restart();
        put(8'hE0); put(8'hF0); put(8'h75); do_tick();
        n_vec++;
        if (dir !== 2'd1 || pending !== 1'b0) begin
            n_err++; $display("FAIL arrow_break: got dir=%0d pend=%0b, want 1/0", dir, pending);
        end
        key_left = 8'h1C; key_up = 8'h1D;
    endtask

    task automatic test_back_to_back();
        restart();
        put(8'h1D); put(8'h1C);
        do_tick();
        n_vec++;
        if (dir !== 2'd0 || turn !== 1'b1) begin
            n_err++; $display("FAIL double_tick1: got dir=%0d turn=%0b, want 0/1", dir, turn);
        end
        do_tick();
`ifdef TURN_QUEUE_EN
        n_vec++;
        if (dir !== 2'd3 || turn !== 1'b1 || pending !== 1'b0) begin
            n_err++; $display("FAIL double_tick2: got dir=%0d turn=%0b, want 3/1", dir, turn);
        end
`else
        n_vec++;
        if (dir !== 2'd0 || turn !== 1'b0 || pending !== 1'b0) begin
            n_err++; $display("FAIL double_tick2: got dir=%0d turn=%0b, want 0/0", dir, turn);
        end
`endif
    endtask

    task automatic test_round_start();
        restart();
        cyc(1, 8'h1D, 0, 1, 1, 1);
        n_vec++;
        if (dir !== 2'd1 || pending !== 1'b0) begin
            n_err++; $display("FAIL rs_priority: got dir=%0d pend=%0b, want 1/0", dir, pending);
        end
        put(8'hE0);
        cyc(0, 8'h00, 0, 0, 1, 0);
        put(8'h1D); do_tick();
        n_vec++;
        if (dir !== 2'd0) begin
            n_err++; $display("FAIL reset_mid_ext: got dir=%0d want 0", dir);
        end
        // A pending break prefix must also be forgotten on reset.
        put(8'hF0);
        cyc(0, 8'h00, 0, 0, 1, 0);
        put(8'h1D); do_tick();
        n_vec++;
        if (dir !== 2'd0 || turn !== 1'b1) begin
            n_err++; $display("FAIL reset_mid_brk: got dir=%0d turn=%0b, want 0/1", dir, turn);
        end
    endtask

    task automatic test_enable();
        restart();
        put(8'h1D);
        cyc(0, 8'h00, 0, 0, 0, 1);
        n_vec++;
        if (pending !== 1'b0) begin
            n_err++; $display("FAIL enable_clear: got pend=%0b want 0", pending);
        end
        cyc(1, 8'h1D, 0, 0, 0, 1);
        cyc(0, 8'h00, 1, 0, 0, 1);
        n_vec++;
        if (dir !== 2'd1 || turn !== 1'b0 || pending !== 1'b0) begin
            n_err++; $display("FAIL enable_off: got dir=%0d turn=%0b pend=%0b, want 1/0/0", dir, turn, pending);
        end
    endtask

    task automatic test_random();
        bit [7:0] codes[8];
        bit [7:0] c;
        codes[0] = 8'h1C; codes[1] = 8'h23; codes[2] = 8'h1D; codes[3] = 8'h1B;
        codes[4] = 8'hE0; codes[5] = 8'hF0; codes[6] = 8'hE1; codes[7] = 8'h55;
        restart();
        for (int i = 0; i < 600; i++) begin
            c = codes[$urandom_range(0, 7)];
            cyc($urandom_range(0, 2) != 0, c, $urandom_range(0, 3) == 0,
                $urandom_range(0, 60) == 0, $urandom_range(0, 25) != 0,
                $urandom_range(0, 80) != 0);
            n_vec++;
            if (dir !== 2'(m_dir) || turn !== 1'(m_turn) || pending !== (m_q.size() != 0)) begin
                n_err++;
                $display("FAIL random[%0d]: got dir=%0d turn=%0b pend=%0b, want %0d/%0d/%0b",
                         i, dir, turn, pending, m_dir, m_turn, m_q.size() != 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_turn();
        test_reversal();
        test_break();
        test_arrow();
        test_back_to_back();
        test_round_start();
        test_enable();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_direction_latch.md
Name: ps2_direction_latch

Overview:
- Sits downstream of the per-player keyset mapping stage and downstream of the PS/2 byte receiver.
- Parses the raw PS/2 scan-code byte stream, handling the E0 (extended) and F0 (break) prefixes.
- Matches make codes against the player's four mapped codes and rejects 180° reversals.
- Holds the resulting heading, which it commits only on the game-step tick; its output feeds the bike position/trail logic.

Parameters:
- INIT_DIR, 2'd1, heading loaded at reset and at round_start (0=up, 1=right, 2=down, 3=left).
- QDEPTH, 2, depth of the turn queue. Only used when TURN_QUEUE_EN is defined; otherwise fixed at 1.

Ports:
- clock  in  1  system clock
- resetn  in  1  synchronous active-low reset
- scan_valid  in  1  one-cycle strobe: scan_code holds a new byte
- scan_code  in  8  PS/2 byte from the receiver
- key_left  in  8  mapped left make code
- key_right  in  8  mapped right make code
- key_up  in  8  mapped up make code
- key_down  in  8  mapped down make code
- enable  in  1  1 = game running; presses are accepted
- tick  in  1  one-cycle game-step strobe
- round_start  in  1  synchronous reload to INIT_DIR
- dir  out  2  committed heading
- turn  out  1  one-cycle pulse when dir changed on a tick
- pending  out  1  1 = a queued turn awaits the next tick

Behaviour:
- Reset (resetn=0 at a clock edge): dir=INIT_DIR, turn=0, pending=0, queue empty, parser in IDLE.
- Parser FSM advances only on scan_valid=1 (4 states: IDLE, EXT, BRK, EXT_BRK).
  - IDLE: E0 -> EXT; F0 -> BRK; E1 -> IDLE, byte ignored; any other byte is a make candidate and the FSM stays in IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> EXT; any other byte is a make candidate, then IDLE.
  - BRK and EXT_BRK: the next byte is consumed as a break code and discarded, then IDLE.
- Code matching ignores the E0 prefix: only the 8-bit value is compared.
  - Priority if the mapped codes collide: up > right > down > left.
  - A candidate that matches none of the four codes is dropped.
- Acceptance of a matched candidate with heading h, where ref = the newest queued entry if the queue is non-empty, else dir:
  - Requires enable=1.
  - h == ref: dropped (this absorbs typematic repeats).
  - h == ref^2 (reversal): dropped.
  - Otherwise h is pushed to the queue.
  - Queue full: the newest entry is overwritten with h, but only if h is legal against the entry below it (or against dir when depth is 1).
- On tick=1:
  - Queue non-empty: the oldest entry is popped into dir at that edge, and turn=1 for the following cycle only.
  - Queue empty: dir is unchanged and turn=0.
- Latency: a scan byte accepted at edge N is visible on pending at N+1. dir changes at the first tick edge at or after N+1.
- Tick and acceptance in the same cycle: the pop happens first. The accept's ref is evaluated against the post-pop state (the next-oldest entry, or the popped value).
- round_start=1: same effect as reset on dir, queue, turn and parser, and takes priority over tick and scan_valid in the same cycle. resetn has priority over round_start.
- enable=0: the parser keeps tracking prefixes and candidates are dropped. The queue is cleared on the falling edge of enable. tick is still honoured, and with the queue cleared it has no effect.
- pending = queue non-empty.

Optional Feature:
- TURN_QUEUE_EN defined: the queue is QDEPTH entries deep. Fast double turns (e.g. up then left within one tick period) are applied on successive ticks.
- TURN_QUEUE_EN undefined: a single-entry holding register. A later legal press replaces the held one, with legality checked against dir.

Decomposition:
- Shared package (lightbike_pkg):
  - Direction encoding constants DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT.
  - PS2_EXT = 8'hE0, PS2_BRK = 8'hF0, PS2_PAUSE = 8'hE1.
  - Parser state encoding.
- One natural sub-module: ps2_prefix_parser. It implements the 4-state FSM and outputs a one-cycle make_valid with make_code.

Test Plan:
- Setup: key_left=1C, key_right=23, key_up=1D, key_down=1B, INIT_DIR=1, enable=1.
- Bytes 1D then tick -> dir=0 the cycle after the tick edge, turn pulses for 1 cycle, pending goes 1 then 0.
- Bytes 1C (reversal of right) then tick -> dir stays 1, turn=0, pending never set.
- Bytes F0,1D then tick -> the break code is discarded and dir stays 1.
- Arrow keys: key_left=6B, key_up=75; bytes E0,75 then tick -> dir=0. Bytes E0,F0,75 -> ignored.
- With TURN_QUEUE_EN: bytes 1D,1C, then tick, tick -> dir goes 0 then 3, with turn pulsing on each tick. Without TURN_QUEUE_EN: 1C is checked against dir=1, is a reversal and is dropped, so the result is dir=0 only.
- scan_valid of 1D in the same cycle as round_start -> dir=INIT_DIR=1 and pending=0. Then resetn=0 for 1 cycle mid-sequence (after E0) -> parser returns to IDLE, so a following 1D is treated as a plain make.
